// File: rtl/iir_ctrl.sv
// iir_ctrl: block sequencer for a single IIR core.
// It clears the core, streams len samples from the read memory through the
// core in ascending order, and writes each result to the same index of the
// write memory. A valid shift register tracks samples in flight, and stall
// freezes that pipeline so that no sample is lost or repeated.
module iir_ctrl #(
  parameter int ADDR_W = 20,
  parameter int LAT    = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] len,
  input  logic              stall,
  output logic              ren,
  output logic [ADDR_W-1:0] raddr,
  input  logic [15:0]       rdata,
  output logic              core_clr,
  output logic              core_en,
  output logic [15:0]       core_din,
  input  logic [15:0]       core_y,
  output logic              wen,
  output logic [ADDR_W-1:0] waddr,
  output logic [15:0]       wdata,
  output logic              busy,
  output logic              done
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_CLEAR = 3'd1;
  localparam logic [2:0] S_RUN   = 3'd2;
  localparam logic [2:0] S_DRAIN = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;

  localparam logic [ADDR_W-1:0] CNT_ZERO = {ADDR_W{1'b0}};
  localparam logic [ADDR_W-1:0] CNT_ONE  = {{(ADDR_W-1){1'b0}}, 1'b1};

  logic [2:0]        state_r;
  logic [2:0]        state_nxt_s;
  logic [ADDR_W-1:0] len_r;
  logic [ADDR_W-1:0] rd_cnt_r;
  logic [ADDR_W-1:0] wr_cnt_r;
  logic [ADDR_W-1:0] wr_cnt_nxt_s;
  // Stage 0 of the valid pipeline is the read issued this cycle (ren_s).
  // Stage k (k >= 1) is registered here. Stage 1 lines up with rdata being
  // valid, and stage 1+LAT lines up with core_y being valid.
  logic [LAT+1:1]    vld_r;
  logic              ren_s;
  logic              wen_s;

  // Issue decode: reads, core steps and writes are all gated by stall
  always_comb begin
    ren_s = (state_r == S_RUN) & ~stall;
    wen_s = vld_r[LAT+1] & ~stall;
    if (wen_s) begin
      wr_cnt_nxt_s = wr_cnt_r + CNT_ONE;
    end else begin
      wr_cnt_nxt_s = wr_cnt_r;
    end
  end

  // Next-state logic. DRAIN looks at the post-write count so that done
  // follows the final write without a bubble cycle.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      S_IDLE: begin
        if (start) begin
          state_nxt_s = S_CLEAR;
        end else begin
          state_nxt_s = S_IDLE;
        end
      end
      S_CLEAR: begin
        if (len_r == CNT_ZERO) begin
          state_nxt_s = S_DONE;
        end else begin
          state_nxt_s = S_RUN;
        end
      end
      S_RUN: begin
        if (ren_s && (rd_cnt_r == (len_r - CNT_ONE))) begin
          state_nxt_s = S_DRAIN;
        end else begin
          state_nxt_s = S_RUN;
        end
      end
      S_DRAIN: begin
        if (wr_cnt_nxt_s == len_r) begin
          state_nxt_s = S_DONE;
        end else begin
          state_nxt_s = S_DRAIN;
        end
      end
      S_DONE:  state_nxt_s = S_IDLE;
      default: state_nxt_s = S_IDLE;
    endcase
  end

  // State, latched length and read/write counters
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r  <= S_IDLE;
      len_r    <= CNT_ZERO;
      rd_cnt_r <= CNT_ZERO;
      wr_cnt_r <= CNT_ZERO;
    end else begin
      state_r <= state_nxt_s;
      if ((state_r == S_IDLE) && start) begin
        len_r <= len;
      end
      if (state_r == S_CLEAR) begin
        rd_cnt_r <= CNT_ZERO;
        wr_cnt_r <= CNT_ZERO;
      end else begin
        if (ren_s) begin
          rd_cnt_r <= rd_cnt_r + CNT_ONE;
        end
        wr_cnt_r <= wr_cnt_nxt_s;
      end
    end
  end

  // Valid pipeline: it shifts only on unstalled cycles and is emptied in CLEAR
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      vld_r <= {(LAT+1){1'b0}};
    end else if (state_r == S_CLEAR) begin
      vld_r <= {(LAT+1){1'b0}};
    end else if (!stall) begin
      vld_r <= {vld_r[LAT:1], ren_s};
    end
  end

  assign ren      = ren_s;
  assign raddr    = rd_cnt_r;
  assign core_clr = (state_r == S_CLEAR);
  assign core_en  = vld_r[1] & ~stall;
  assign core_din = rdata;
  assign wen      = wen_s;
  assign waddr    = wr_cnt_r;
  assign wdata    = core_y;
  assign busy     = (state_r != S_IDLE);
  assign done     = (state_r == S_DONE);

endmodule

// File: tb/tb_iir_ctrl.sv
// Directed bench for iir_ctrl.
// Two instances run under test: one with LAT=1 and one with LAT=3. Each has
// its own memory model and core model.
module tb_iir_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic stall = 1'b0;

  logic        start1 = 1'b0;
  logic [19:0] len1 = 20'd0;
  logic        ren1, clr1, cen1, wen1, busy1, done1;
  logic [19:0] raddr1, waddr1;
  logic [15:0] rdata1 = 16'h0;
  logic [15:0] din1, wdata1;
  logic [15:0] y1 = 16'h0;

  logic        start3 = 1'b0;
  logic [19:0] len3 = 20'd0;
  logic        ren3, clr3, cen3, wen3, busy3, done3;
  logic [19:0] raddr3, waddr3;
  logic [15:0] rdata3 = 16'h0;
  logic [15:0] din3, wdata3;
  logic [15:0] p3 [3];

  logic [15:0] mem [16];
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  iir_ctrl #(.ADDR_W(20), .LAT(1)) u_dut1 (
    .clk(clk), .rst(rst), .start(start1), .len(len1), .stall(stall),
    .ren(ren1), .raddr(raddr1), .rdata(rdata1), .core_clr(clr1),
    .core_en(cen1), .core_din(din1), .core_y(y1), .wen(wen1),
    .waddr(waddr1), .wdata(wdata1), .busy(busy1), .done(done1)
  );

  iir_ctrl #(.ADDR_W(20), .LAT(3)) u_dut3 (
    .clk(clk), .rst(rst), .start(start3), .len(len3), .stall(stall),
    .ren(ren3), .raddr(raddr3), .rdata(rdata3), .core_clr(clr3),
    .core_en(cen3), .core_din(din3), .core_y(p3[2]), .wen(wen3),
    .waddr(waddr3), .wdata(wdata3), .busy(busy3), .done(done3)
  );

  function automatic logic [15:0] f(input logic [15:0] x);
    return x ^ 16'h5A5A;
  endfunction

  // Read memories: data appears one cycle after ren and holds otherwise
  always @(posedge clk) begin
    if (ren1) rdata1 <= mem[raddr1[3:0]];
    if (ren3) rdata3 <= mem[raddr3[3:0]];
  end

  // LAT=1 core: the output advances only on core_en
  always @(posedge clk) begin
    if (clr1) y1 <= 16'h0;
    else if (cen1) y1 <= f(din1);
  end

  // LAT=3 core: a three-stage pipeline that advances on unstalled cycles
  always @(posedge clk) begin
    if (clr3) begin
      p3[0] <= 16'h0; p3[1] <= 16'h0; p3[2] <= 16'h0;
    end else if (!stall) begin
      p3[0] <= cen3 ? f(din3) : 16'h0;
      p3[1] <= p3[0];
      p3[2] <= p3[1];
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Runs one block on the LAT=1 instance. Call it at a negedge: that is
  // cycle 0. rs_cyc is the cycle of a stray start pulse with len=9.
  task automatic run1(input int n, input int s_lo, input int s_hi, input int rs_cyc,
                      output int clr_cyc, output int done_cyc, output int nrd,
                      output int nwr, output int bad);
    int cyc;
    clr_cyc = -1; done_cyc = -1; nrd = 0; nwr = 0; bad = 0;
    len1 = 20'(n);
    start1 = 1'b1;
    stall = 1'b0;
    step();
    start1 = 1'b0;
    cyc = 1;
    while (cyc < 60 && (done_cyc < 0 || cyc <= done_cyc + 1)) begin
      stall = (cyc >= s_lo && cyc <= s_hi);
      if (cyc == rs_cyc) begin
        start1 = 1'b1;
        len1 = 20'd9;
      end else begin
        start1 = 1'b0;
      end
      #1;
      if (stall && (ren1 || cen1 || wen1)) bad++;
      if (clr1 && cen1) bad++;
      if (clr1) clr_cyc = cyc;
      if (ren1) begin
        check("raddr_seq", 32'(raddr1), 32'(nrd));
        nrd++;
      end
      if (wen1) begin
        check("waddr_seq", 32'(waddr1), 32'(nwr));
        check("wdata_val", 32'(wdata1), 32'(f(mem[nwr[3:0]])));
        nwr++;
      end
      if (done1) done_cyc = cyc;
      if (done_cyc >= 0 && cyc == done_cyc + 1) check("busy_after_done", 32'(busy1), 32'd0);
      step();
      cyc++;
    end
    stall = 1'b0;
    start1 = 1'b0;
  endtask

  typedef struct {
    logic clr; logic ren; int ra; logic cen; logic wen; int wa; logic dn; logic bsy;
  } vec_t;
  vec_t tbl [10];

  initial begin
    int clr_c, done_c, nrd, nwr, bad;

    for (int i = 0; i < 16; i++) mem[i] = 16'h1000 + 16'(i * 37);

    //          clr   ren   ra  cen   wen   wa  done  busy
    tbl[0] = '{1'b0, 1'b0, 0, 1'b0, 1'b0, 0, 1'b0, 1'b0};
    tbl[1] = '{1'b1, 1'b0, 0, 1'b0, 1'b0, 0, 1'b0, 1'b1};
    tbl[2] = '{1'b0, 1'b1, 0, 1'b0, 1'b0, 0, 1'b0, 1'b1};
    tbl[3] = '{1'b0, 1'b1, 1, 1'b1, 1'b0, 0, 1'b0, 1'b1};
    tbl[4] = '{1'b0, 1'b1, 2, 1'b1, 1'b1, 0, 1'b0, 1'b1};
    tbl[5] = '{1'b0, 1'b1, 3, 1'b1, 1'b1, 1, 1'b0, 1'b1};
    tbl[6] = '{1'b0, 1'b0, 0, 1'b1, 1'b1, 2, 1'b0, 1'b1};
    tbl[7] = '{1'b0, 1'b0, 0, 1'b0, 1'b1, 3, 1'b0, 1'b1};
    tbl[8] = '{1'b0, 1'b0, 0, 1'b0, 1'b0, 0, 1'b1, 1'b1};
    tbl[9] = '{1'b0, 1'b0, 0, 1'b0, 1'b0, 0, 1'b0, 1'b0};

    // Reset state
    step();
    #1;
    check("rst_ren", 32'(ren1), 32'd0);
    check("rst_busy", 32'(busy1), 32'd0);
    check("rst_raddr", 32'(raddr1), 32'd0);
    check("rst_waddr", 32'(waddr1), 32'd0);
    check("rst_done", 32'(done1), 32'd0);
    check("rst_busy3", 32'(busy3), 32'd0);
    step();
    rst = 1'b1;
    step();

    // LAT=1, len=4, no stall: compare against the table one cycle at a time
    len1 = 20'd4;
    start1 = 1'b1;
    for (int k = 0; k < 10; k++) begin
      #1;
      check("t_clr", 32'(clr1), 32'(tbl[k].clr));
      check("t_ren", 32'(ren1), 32'(tbl[k].ren));
      if (tbl[k].ren) check("t_raddr", 32'(raddr1), 32'(tbl[k].ra));
      check("t_core_en", 32'(cen1), 32'(tbl[k].cen));
      check("t_wen", 32'(wen1), 32'(tbl[k].wen));
      if (tbl[k].wen) begin
        check("t_waddr", 32'(waddr1), 32'(tbl[k].wa));
        check("t_wdata", 32'(wdata1), 32'(f(mem[tbl[k].wa])));
      end
      check("t_done", 32'(done1), 32'(tbl[k].dn));
      check("t_busy", 32'(busy1), 32'(tbl[k].bsy));
      step();
      start1 = 1'b0;
    end

    // LAT=1, len=6, stall high for cycles 5-7
    run1(6, 5, 7, -1, clr_c, done_c, nrd, nwr, bad);
    check("stall_done_cyc", 32'(done_c), 32'd13);
    check("stall_reads", 32'(nrd), 32'd6);
    check("stall_writes", 32'(nwr), 32'd6);
    check("stall_no_enables", 32'(bad), 32'd0);

    // len=0: clear, then done, with no traffic
    step();
    run1(0, -1, -1, -1, clr_c, done_c, nrd, nwr, bad);
    check("len0_clr_cyc", 32'(clr_c), 32'd1);
    check("len0_done_cyc", 32'(done_c), 32'd2);
    check("len0_reads", 32'(nrd), 32'd0);
    check("len0_writes", 32'(nwr), 32'd0);

    // A start pulse while busy is ignored
    step();
    run1(4, -1, -1, 4, clr_c, done_c, nrd, nwr, bad);
    check("busy_start_done_cyc", 32'(done_c), 32'd8);
    check("busy_start_reads", 32'(nrd), 32'd4);
    check("busy_start_writes", 32'(nwr), 32'd4);
    for (int k = 0; k < 3; k++) begin
      #1;
      check("no_second_block", 32'(busy1), 32'd0);
      step();
    end

    // Asynchronous reset at cycle 5 of a len=8 block
    len1 = 20'd8;
    start1 = 1'b1;
    step();
    start1 = 1'b0;
    for (int k = 0; k < 4; k++) step();
    #1;
    check("pre_rst_ren", 32'(ren1), 32'd1);
    rst = 1'b0;
    #1;
    check("arst_ren", 32'(ren1), 32'd0);
    check("arst_raddr", 32'(raddr1), 32'd0);
    check("arst_core_en", 32'(cen1), 32'd0);
    check("arst_wen", 32'(wen1), 32'd0);
    check("arst_waddr", 32'(waddr1), 32'd0);
    check("arst_busy", 32'(busy1), 32'd0);
    check("arst_done", 32'(done1), 32'd0);
    check("arst_clr", 32'(clr1), 32'd0);
    step();
    rst = 1'b1;
    step();
    run1(2, -1, -1, -1, clr_c, done_c, nrd, nwr, bad);
    check("post_rst_done_cyc", 32'(done_c), 32'd6);
    check("post_rst_writes", 32'(nwr), 32'd2);

    // LAT=3, len=1
    step();
    len3 = 20'd1;
    start3 = 1'b1;
    for (int c = 0; c < 9; c++) begin
      #1;
      check("l3_ren", 32'(ren3), 32'(c == 2));
      if (c == 2) check("l3_raddr", 32'(raddr3), 32'd0);
      check("l3_core_en", 32'(cen3), 32'(c == 3));
      check("l3_wen", 32'(wen3), 32'(c == 6));
      if (c == 6) begin
        check("l3_waddr", 32'(waddr3), 32'd0);
        check("l3_wdata", 32'(wdata3), 32'(f(mem[0])));
      end
      check("l3_done", 32'(done3), 32'(c == 7));
      check("l3_busy", 32'(busy3), 32'(c >= 1 && c <= 7));
      step();
      start3 = 1'b0;
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
